// File: rtl/mu0_control.sv
// Fetch/execute sequencer for the 12-bit MU0 datapath: drives mux selects,
// register enables and memory strobes, with optional memory wait states.
module mu0_control #(
  parameter int WAIT_STATES = 0,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  output logic             Addr_sel,
  output logic             X_sel,
  output logic             Y_sel,
  output logic [1:0]       ALU_fn,
  output logic             PC_En,
  output logic             IR_En,
  output logic             Acc_En,
  output logic             Mem_rd,
  output logic             Mem_wr,
  output logic             Fetch,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] WC_LAST = 4'(WAIT_STATES);

  localparam logic [1:0] FN_Y    = 2'b00;
  localparam logic [1:0] FN_ADD  = 2'b01;
  localparam logic [1:0] FN_INC  = 2'b10;
  localparam logic [1:0] FN_SUB  = 2'b11;

  state_t             state_q, state_d;
  logic [3:0]         wc_q, wc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last;

  assign last      = (wc_q == WC_LAST);
  assign Instr_cnt = cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      wc_q    <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    cnt_d    = cnt_q;
    Addr_sel = 1'b0;
    X_sel    = 1'b0;
    Y_sel    = 1'b0;
    ALU_fn   = FN_Y;
    PC_En    = 1'b0;
    IR_En    = 1'b0;
    Acc_En   = 1'b0;
    Mem_rd   = 1'b0;
    Mem_wr   = 1'b0;
    Fetch    = 1'b0;
    Halted   = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // PC+1 is computed every cycle but only loaded on the final wait cycle
        Addr_sel = 1'b0;
        Mem_rd   = 1'b1;
        X_sel    = 1'b1;
        ALU_fn   = FN_INC;
        Fetch    = 1'b1;
        if (last) begin
          IR_En   = 1'b1;
          PC_En   = 1'b1;
          state_d = S_EXEC;
          wc_d    = 4'd0;
        end else begin
          wc_d = wc_q + 4'd1;
        end
      end

      S_EXEC: begin
        if (F[3:2] == 2'b00) begin
          Addr_sel = 1'b1;
          unique case (F[1:0])
            2'd0: begin
              Mem_rd = 1'b1;
              Y_sel  = 1'b0;
              ALU_fn = FN_Y;
              Acc_En = last;
            end
            2'd1: begin
              Mem_wr = 1'b1;
            end
            2'd2: begin
              Mem_rd = 1'b1;
              X_sel  = 1'b0;
              Y_sel  = 1'b0;
              ALU_fn = FN_ADD;
              Acc_En = last;
            end
            default: begin
              Mem_rd = 1'b1;
              X_sel  = 1'b0;
              Y_sel  = 1'b0;
              ALU_fn = FN_SUB;
              Acc_En = last;
            end
          endcase
          if (last) begin
            state_d = S_FETCH;
            wc_d    = 4'd0;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            wc_d = wc_q + 4'd1;
          end
        end else if (F == 4'd4 || F == 4'd5 || F == 4'd6) begin
          // Jumps never touch memory, so they ignore the wait counter
          Y_sel  = 1'b1;
          ALU_fn = FN_Y;
          if (F == 4'd4)      PC_En = 1'b1;
          else if (F == 4'd5) PC_En = ~N;
          else                PC_En = ~Z;
          state_d = S_FETCH;
          wc_d    = 4'd0;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = S_HALT;
          wc_d    = 4'd0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      S_HALT: begin
        Halted = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
        wc_d    = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: three instances cover zero, two and three
// wait states (the last one with a 4-bit retired-instruction counter).
module tb_mu0_control;

  // Output bundle order: {Addr_sel,X_sel,Y_sel,ALU_fn,PC_En,IR_En,Acc_En,Mem_rd,Mem_wr,Fetch,Halted}
  localparam logic [11:0] O_FETCH   = 12'b0_1_0_10_1_1_0_1_0_1_0;
  localparam logic [11:0] O_FWAIT   = 12'b0_1_0_10_0_0_0_1_0_1_0;
  localparam logic [11:0] O_LDA     = 12'b1_0_0_00_0_0_1_1_0_0_0;
  localparam logic [11:0] O_STA     = 12'b1_0_0_00_0_0_0_0_1_0_0;
  localparam logic [11:0] O_ADD     = 12'b1_0_0_01_0_0_1_1_0_0_0;
  localparam logic [11:0] O_ADDWAIT = 12'b1_0_0_01_0_0_0_1_0_0_0;
  localparam logic [11:0] O_SUB     = 12'b1_0_0_11_0_0_1_1_0_0_0;
  localparam logic [11:0] O_JTAKEN  = 12'b0_0_1_00_1_0_0_0_0_0_0;
  localparam logic [11:0] O_JNOT    = 12'b0_0_1_00_0_0_0_0_0_0_0;
  localparam logic [11:0] O_STOP    = 12'b0_0_0_00_0_0_0_0_0_0_0;
  localparam logic [11:0] O_HALT    = 12'b0_0_0_00_0_0_0_0_0_0_1;

  typedef struct packed {
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic [11:0] exp;
    logic [15:0] cnt;
  } vec_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Instance 0: WAIT_STATES = 0, CNT_W = 16
  logic rst0 = 1'b1, n0 = 1'b0, z0 = 1'b0;
  logic [3:0] f0 = 4'd0;
  logic d0_as, d0_xs, d0_ys, d0_pc, d0_ir, d0_acc, d0_rd, d0_wr, d0_fe, d0_h;
  logic [1:0] d0_fn;
  logic [15:0] d0_cnt;
  logic [11:0] o0;
  assign o0 = {d0_as, d0_xs, d0_ys, d0_fn, d0_pc, d0_ir, d0_acc, d0_rd, d0_wr, d0_fe, d0_h};

  mu0_control #(.WAIT_STATES(0), .CNT_W(16)) dut0 (
    .Clk(Clk), .Reset(rst0), .F(f0), .N(n0), .Z(z0),
    .Addr_sel(d0_as), .X_sel(d0_xs), .Y_sel(d0_ys), .ALU_fn(d0_fn),
    .PC_En(d0_pc), .IR_En(d0_ir), .Acc_En(d0_acc), .Mem_rd(d0_rd), .Mem_wr(d0_wr),
    .Fetch(d0_fe), .Halted(d0_h), .Instr_cnt(d0_cnt)
  );

  // Instance 2: WAIT_STATES = 2, CNT_W = 16
  logic rst2 = 1'b1, n2 = 1'b0, z2 = 1'b0;
  logic [3:0] f2 = 4'd0;
  logic d2_as, d2_xs, d2_ys, d2_pc, d2_ir, d2_acc, d2_rd, d2_wr, d2_fe, d2_h;
  logic [1:0] d2_fn;
  logic [15:0] d2_cnt;
  logic [11:0] o2;
  assign o2 = {d2_as, d2_xs, d2_ys, d2_fn, d2_pc, d2_ir, d2_acc, d2_rd, d2_wr, d2_fe, d2_h};

  mu0_control #(.WAIT_STATES(2), .CNT_W(16)) dut2 (
    .Clk(Clk), .Reset(rst2), .F(f2), .N(n2), .Z(z2),
    .Addr_sel(d2_as), .X_sel(d2_xs), .Y_sel(d2_ys), .ALU_fn(d2_fn),
    .PC_En(d2_pc), .IR_En(d2_ir), .Acc_En(d2_acc), .Mem_rd(d2_rd), .Mem_wr(d2_wr),
    .Fetch(d2_fe), .Halted(d2_h), .Instr_cnt(d2_cnt)
  );

  // Instance 3: WAIT_STATES = 3, CNT_W = 4
  logic rst3 = 1'b1, n3 = 1'b0, z3 = 1'b0;
  logic [3:0] f3 = 4'd2;
  logic d3_as, d3_xs, d3_ys, d3_pc, d3_ir, d3_acc, d3_rd, d3_wr, d3_fe, d3_h;
  logic [1:0] d3_fn;
  logic [3:0] d3_cnt;
  logic [11:0] o3;
  assign o3 = {d3_as, d3_xs, d3_ys, d3_fn, d3_pc, d3_ir, d3_acc, d3_rd, d3_wr, d3_fe, d3_h};

  mu0_control #(.WAIT_STATES(3), .CNT_W(4)) dut3 (
    .Clk(Clk), .Reset(rst3), .F(f3), .N(n3), .Z(z3),
    .Addr_sel(d3_as), .X_sel(d3_xs), .Y_sel(d3_ys), .ALU_fn(d3_fn),
    .PC_En(d3_pc), .IR_En(d3_ir), .Acc_En(d3_acc), .Mem_rd(d3_rd), .Mem_wr(d3_wr),
    .Fetch(d3_fe), .Halted(d3_h), .Instr_cnt(d3_cnt)
  );

  // Inputs change 2 time units after a rising edge; outputs are compared 1 unit later
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: outputs got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: Instr_cnt got %0d expected %0d", name, act, exp);
    end
  endtask

  vec_t vecs[23];

  task automatic applyStimulus();
    for (int i = 0; i < 23; i++) begin
      f0 = vecs[i].f;
      n0 = vecs[i].n;
      z0 = vecs[i].z;
      #1;
      checkOutput($sformatf("ws0_vec%0d", i), o0, vecs[i].exp);
      checkCount($sformatf("ws0_cnt%0d", i), int'(d0_cnt), int'(vecs[i].cnt));
      tick();
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0, 1'b0, 1'b0, O_FETCH,  16'd0};
    vecs[1]  = '{4'd0, 1'b0, 1'b0, O_LDA,    16'd0};
    vecs[2]  = '{4'd1, 1'b0, 1'b0, O_FETCH,  16'd1};
    vecs[3]  = '{4'd1, 1'b0, 1'b0, O_STA,    16'd1};
    vecs[4]  = '{4'd2, 1'b0, 1'b0, O_FETCH,  16'd2};
    vecs[5]  = '{4'd2, 1'b0, 1'b0, O_ADD,    16'd2};
    vecs[6]  = '{4'd3, 1'b0, 1'b0, O_FETCH,  16'd3};
    vecs[7]  = '{4'd3, 1'b0, 1'b0, O_SUB,    16'd3};
    vecs[8]  = '{4'd4, 1'b1, 1'b1, O_FETCH,  16'd4};
    vecs[9]  = '{4'd4, 1'b1, 1'b1, O_JTAKEN, 16'd4};
    vecs[10] = '{4'd5, 1'b1, 1'b0, O_FETCH,  16'd5};
    vecs[11] = '{4'd5, 1'b1, 1'b0, O_JNOT,   16'd5};
    vecs[12] = '{4'd5, 1'b0, 1'b1, O_FETCH,  16'd6};
    vecs[13] = '{4'd5, 1'b0, 1'b1, O_JTAKEN, 16'd6};
    vecs[14] = '{4'd6, 1'b0, 1'b1, O_FETCH,  16'd7};
    vecs[15] = '{4'd6, 1'b0, 1'b1, O_JNOT,   16'd7};
    vecs[16] = '{4'd6, 1'b1, 1'b0, O_FETCH,  16'd8};
    vecs[17] = '{4'd6, 1'b1, 1'b0, O_JTAKEN, 16'd8};
    vecs[18] = '{4'd7, 1'b0, 1'b0, O_FETCH,  16'd9};
    vecs[19] = '{4'd7, 1'b0, 1'b0, O_STOP,   16'd9};
    vecs[20] = '{4'd7, 1'b0, 1'b0, O_HALT,   16'd10};
    vecs[21] = '{4'd0, 1'b0, 1'b0, O_HALT,   16'd10};
    vecs[22] = '{4'd2, 1'b1, 1'b1, O_HALT,   16'd10};

    // Zero wait states: table of one instruction of each kind ending in STP
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    applyStimulus();

    // Reset out of HALT, then an undefined opcode also halts
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    f0 = 4'd9;
    #1;
    checkOutput("ws0_reset_from_halt", o0, O_FETCH);
    checkCount("ws0_reset_cnt", int'(d0_cnt), 0);
    tick();
    #1;
    checkOutput("ws0_undef_exec", o0, O_STOP);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("ws0_undef_halt%0d", i), o0, O_HALT);
      checkCount($sformatf("ws0_undef_cnt%0d", i), int'(d0_cnt), 1);
      tick();
    end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    #1;
    checkOutput("ws0_reset_again", o0, O_FETCH);
    checkCount("ws0_reset_again_cnt", int'(d0_cnt), 0);

    // Two wait states: STA stretches both FETCH and EXEC to three cycles
    f2 = 4'd1;
    tick();
    rst2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput($sformatf("ws2_fetch_wait%0d", i), o2, O_FWAIT);
      tick();
    end
    #1;
    checkOutput("ws2_fetch_last", o2, O_FETCH);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("ws2_sta%0d", i), o2, O_STA);
      checkCount($sformatf("ws2_sta_cnt%0d", i), int'(d2_cnt), 0);
      tick();
    end
    f2 = 4'd4;
    #1;
    checkOutput("ws2_after_sta", o2, O_FWAIT);
    checkCount("ws2_after_sta_cnt", int'(d2_cnt), 1);
    tick();
    tick();
    #1;
    checkOutput("ws2_jmp_fetch_last", o2, O_FETCH);
    tick();
    #1;
    checkOutput("ws2_jmp_single", o2, O_JTAKEN);
    tick();
    #1;
    checkOutput("ws2_after_jmp", o2, O_FWAIT);
    checkCount("ws2_after_jmp_cnt", int'(d2_cnt), 2);

    // Three wait states: reset lands in the 2nd ADD EXEC cycle
    f3 = 4'd2;
    tick();
    rst3 = 1'b0;
    repeat (3) tick();
    #1;
    checkOutput("ws3_fetch_last", o3, O_FETCH);
    tick();
    #1;
    checkOutput("ws3_add_exec0", o3, O_ADDWAIT);
    tick();
    rst3 = 1'b1;
    #1;
    checkOutput("ws3_add_exec1_in_reset", o3, O_ADDWAIT);
    tick();
    rst3 = 1'b0;
    #1;
    checkOutput("ws3_post_reset", o3, O_FWAIT);
    checkCount("ws3_post_reset_cnt", int'(d3_cnt), 0);

    // Seventeen ADDs with a 4-bit counter: first one checked cycle by cycle
    for (int c = 0; c < 8; c++) begin
      logic [11:0] e;
      if (c < 3)       e = O_FWAIT;
      else if (c == 3) e = O_FETCH;
      else if (c < 7)  e = O_ADDWAIT;
      else             e = O_ADD;
      #1;
      checkOutput($sformatf("ws3_add1_cyc%0d", c), o3, e);
      tick();
    end
    #1;
    checkCount("ws3_cnt_after1", int'(d3_cnt), 1);
    for (int k = 2; k <= 17; k++) begin
      repeat (8) tick();
      #1;
      checkCount($sformatf("ws3_cnt_after%0d", k), int'(d3_cnt), k % 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
